data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: master 0 (CPU load/store stage) and master 1 (peripheral/DMA engine).
- Arbitrates every cycle, drives the memory port from the winning master, and routes registered read data back to that master.
- Bounds CPU hogging with a burst limit so master 1 cannot starve.
- Sits between the CPU datapath, the peripheral bus and the data memory; the existing data-memory print monitor attaches to its memory-side signals.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_BURST, 4, max consecutive grants to one master while the other is requesting; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  access request, held until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_gnt / m1_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid (one cycle after grant)
- m0_rdata / m1_rdata  out  DATA_W  read data
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rd / mem_wr  out  1  memory read / write strobes
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd

Behaviour:
- Reset values (async, active-high):
  - State = IDLE, last_owner = 0, burst_cnt = 0.
  - All rvalid outputs = 0; rdata outputs = 0.
  - With no requests, gnt, mem_rd and mem_wr = 0 and mem_addr/mem_wdata = 0.
- FSM:
  - States are IDLE, OWN0 and OWN1, held in registers as {active, last_owner}.
  - burst_cnt is 4 bits and saturates at MAX_BURST.
- Grant decision (combinational from state and requests):
  - Only one master requests: that master wins.
  - Both request, burst_cnt < MAX_BURST: last_owner wins (sticky). After reset this gives master 0 priority.
  - Both request, burst_cnt >= MAX_BURST: the other master wins.
  - Neither requests: no grant.
- State and counter update at posedge clk:
  - Grant to the same master as last_owner: burst_cnt = sat(burst_cnt + 1); state = OWNx.
  - Grant to the other master: last_owner flips, burst_cnt = 1.
  - No grant: state = IDLE, burst_cnt = 0, last_owner held.
- Memory port:
  - mem_addr and mem_wdata mux from the winner in the same cycle.
  - mem_rd = gnt & ~we; mem_wr = gnt & we.
  - Exactly one gnt is high per cycle, at most.
- Read return:
  - A registered tag {pending, owner} captures each granted read.
  - Next cycle, mx_rvalid = 1 for the tagged owner only and mx_rdata = mem_rdata.
  - The non-owner's rdata holds its previous value.
  - Writes never raise rvalid.
  - Latency is one cycle; back-to-back reads give one rvalid per cycle.
- Requesters must hold req, we, addr and wdata stable until gnt; a deasserted req is simply not arbitrated.
- Reset mid-operation: a pending read is dropped (no rvalid) and the FSM returns to IDLE immediately.
- MAX_BURST = 1 gives strict alternation under continuous contention.

Optional Feature:
- Macro: DATA_MEM_ARB_TRACE_EN.
- Defined (simulation only):
  - On each posedge with a grant, $display the master index, "read"/"write", address and data in hex and decimal.
  - On each forced hand-off (burst limit hit), print "arb: burst limit, switch to m<x>".
- Undefined: no display code is compiled and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - localparams OWN_IDLE / OWN0 / OWN1 state encodings.
  - The master-index constants.
  - The burst counter width (4).
- One natural sub-module, data_mem_arb_rr: the grant-decision and burst-counter logic.
  - Inputs: requests, last_owner, burst_cnt.
  - Output: one-hot grant.
  - The top level keeps the muxes and read-return tag.

Test Plan:
- Reset, then m0 reads addr 0x10 (memory holds 0x12345678): m0_gnt same cycle, mem_rd = 1; next cycle m0_rvalid = 1 and m0_rdata = 0x12345678; m1_rvalid stays 0.
- Both masters request continuously with MAX_BURST = 4: grants go m0 ×4, m1 ×4, m0 ×4…, never more than 4 consecutive.
- m1 writes 0xDEADBEEF to 0x20, then m0 reads 0x20: mem_wr pulse with m1's data, no rvalid for the write; m0_rdata = 0xDEADBEEF.
- Reset asserted in the cycle after a granted m0 read: m0_rvalid stays 0, state is IDLE, and the next tie grants m0.
- Alternating single requests m0, m1, m0 with no overlap: each is granted in its request cycle and burst_cnt is 1 after each grant.
- Compile with DATA_MEM_ARB_TRACE_EN and run the contention test: a log line appears for every grant plus one "burst limit" line per forced switch.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: ownership states, master indices,
// burst counter width and the saturating burst increment.
package data_mem_arbiter_pkg;

    localparam int BURST_W = 4;

    // State register is {active, last_owner}
    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN0     = 2'b10;
    localparam logic [1:0] OWN1     = 2'b11;

    localparam logic MST0 = 1'b0;
    localparam logic MST1 = 1'b1;

    // Idle keeps last_owner, so idle has two encodings
    typedef enum logic [1:0] {
        ST_IDLE    = OWN_IDLE,
        ST_IDLE_L1 = 2'b01,
        ST_OWN0    = OWN0,
        ST_OWN1    = OWN1
    } arb_state_e;

    function automatic logic [BURST_W-1:0] burst_inc(input logic [BURST_W-1:0] cnt,
                                                     input logic [BURST_W-1:0] max_cnt);
        return (cnt >= max_cnt) ? max_cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/data_mem_arb_rr.sv
// Grant decision for the data-memory arbiter: sticky ownership with a burst
// limit that hands the port to the other master once the limit is reached.
module data_mem_arb_rr
    import data_mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               m0_req_i,
    input  logic               m1_req_i,
    input  logic               last_owner_i,
    input  logic [BURST_W-1:0] burst_cnt_i,
    output logic [1:0]         gnt_o
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

    always_comb begin
        gnt_o = 2'b00;
        case ({m1_req_i, m0_req_i})
            2'b01: gnt_o = 2'b01;
            2'b10: gnt_o = 2'b10;
            2'b11: begin
                if (burst_cnt_i < MAX_B) gnt_o = last_owner_i ? 2'b10 : 2'b01;
                else                     gnt_o = last_owner_i ? 2'b01 : 2'b10;
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the single-port data memory with one-cycle read return.
// Optional grant trace: define DATA_MEM_ARB_TRACE_EN (simulation only).
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

    arb_state_e         state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [1:0]         gnt;
    logic               last_owner;
    logic               win_we;
    logic               rd_pend_q;
    logic               rd_owner_q;
    logic [DATA_W-1:0]  m0_rdata_q, m1_rdata_q;

    assign last_owner = state_q[0];

    data_mem_arb_rr #(
        .MAX_BURST(MAX_BURST)
    ) u_rr (
        .m0_req_i    (m0_req),
        .m1_req_i    (m1_req),
        .last_owner_i(last_owner),
        .burst_cnt_i (burst_q),
        .gnt_o       (gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        if (gnt[1]) begin
            state_d = ST_OWN1;
            burst_d = (last_owner == MST1) ? burst_inc(burst_q, MAX_B) : BURST_W'(1);
        end else if (gnt[0]) begin
            state_d = ST_OWN0;
            burst_d = (last_owner == MST0) ? burst_inc(burst_q, MAX_B) : BURST_W'(1);
        end else begin
            state_d = last_owner ? ST_IDLE_L1 : ST_IDLE;
            burst_d = '0;
        end
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign win_we    = gnt[1] ? m1_we : m0_we;
    assign mem_addr  = gnt[1] ? m1_addr  : (gnt[0] ? m0_addr  : '0);
    assign mem_wdata = gnt[1] ? m1_wdata : (gnt[0] ? m0_wdata : '0);
    assign mem_rd    = (|gnt) & ~win_we;
    assign mem_wr    = (|gnt) &  win_we;

    // Read tag: memory data arrives the cycle after mem_rd, steered to the tagged owner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= MST0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            rd_pend_q  <= mem_rd;
            rd_owner_q <= gnt[1];
            if (m0_rvalid) m0_rdata_q <= mem_rdata;
            if (m1_rvalid) m1_rdata_q <= mem_rdata;
        end
    end

    assign m0_rvalid = rd_pend_q & (rd_owner_q == MST0);
    assign m1_rvalid = rd_pend_q & (rd_owner_q == MST1);
    assign m0_rdata  = m0_rvalid ? mem_rdata : m0_rdata_q;
    assign m1_rdata  = m1_rvalid ? mem_rdata : m1_rdata_q;

`ifdef DATA_MEM_ARB_TRACE_EN
    always @(posedge clk) begin
        if (!reset && (|gnt)) begin
            $display("arb: m%0d %s addr=0x%h (%0d) data=0x%h (%0d)", gnt[1],
                     win_we ? "write" : "read", mem_addr, mem_addr, mem_wdata, mem_wdata);
            if (m0_req && m1_req && (burst_q >= MAX_B))
                $display("arb: burst limit, switch to m%0d", gnt[1]);
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level arbitration and memory model.
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk, reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_rd, mem_wr;

    int total = 0;
    int bad   = 0;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory environment: 64 words, registered read, preload port
    logic [DW-1:0] tb_mem [64];
    logic          ld_en;
    logic [5:0]    ld_addr;
    logic [DW-1:0] ld_data;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= 32'hC0DE0000 + i;
            mem_rdata <= '0;
        end else begin
            if (ld_en)  tb_mem[ld_addr] <= ld_data;
            if (mem_wr) tb_mem[mem_addr[5:0]] <= mem_wdata;
            if (mem_rd) mem_rdata <= tb_mem[mem_addr[5:0]];
        end
    end

    // Reference model: memory contents, run length of the current owner, pending read
    logic [DW-1:0] ref_mem [64];
    logic          m_last;
    int            m_run;
    logic          m_pend, m_pend_own;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] m_rdata [2];

    task automatic model_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'hC0DE0000 + i;
        m_last = 1'b0; m_run = 0; m_pend = 1'b0; m_pend_own = 1'b0; m_pend_data = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    function automatic logic [1:0] model_gnt(input logic r0, input logic r1);
        if (r0 && !r1) return 2'b01;
        if (r1 && !r0) return 2'b10;
        if (!r0 && !r1) return 2'b00;
        if (m_run < MB) return m_last ? 2'b10 : 2'b01;
        return m_last ? 2'b01 : 2'b10;
    endfunction

    task automatic model_step(input logic [1:0] g, input logic we, input logic [5:0] a,
                              input logic [DW-1:0] wd);
        logic w;
        if (m_pend) m_rdata[m_pend_own] = m_pend_data;
        m_pend = 1'b0;
        if (g != 2'b00) begin
            w = g[1];
            if (we) ref_mem[a] = wd;
            else begin
                m_pend = 1'b1; m_pend_own = w; m_pend_data = ref_mem[a];
            end
            if (w == m_last) m_run = (m_run < MB) ? m_run + 1 : MB;
            else begin
                m_last = w; m_run = 1;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        ld_en = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic preload(input logic [5:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        ref_mem[a] = d;
        model_step(2'b00, 1'b0, '0, '0);
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        ld_en = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        total++;
        if ({m0_gnt, m1_gnt, mem_rd, mem_wr} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes: got %b want 0000", {m0_gnt, m1_gnt, mem_rd, mem_wr});
        end
        total++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            bad++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        end
        total++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== '0 || m1_rdata !== '0) begin
            bad++; $display("FAIL reset_read_return: got rv=%b rd0=%h rd1=%h want 0",
                            {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
        end
        total++;
        if (dut.state_q !== ST_IDLE || dut.burst_q !== 4'd0) begin
            bad++; $display("FAIL reset_state: got state=%b burst=%0d want 00/0", dut.state_q, dut.burst_q);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        preload(6'h10, 32'h12345678);
        @(negedge clk);
        drive(1, 0, 32'h10, '0, 0, 0, '0, '0);
        #1;
        total++;
        if ({m0_gnt, m1_gnt, mem_rd, mem_wr} !== 4'b1010 || mem_addr !== 32'h10) begin
            bad++; $display("FAIL rd_grant: got gnt/rd/wr=%b addr=%h want 1010 addr=10",
                            {m0_gnt, m1_gnt, mem_rd, mem_wr}, mem_addr);
        end
        model_step(2'b01, 1'b0, 6'h10, '0);
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        total++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h12345678 || m1_rvalid !== 1'b0) begin
            bad++; $display("FAIL rd_return: got rv0=%b rd0=%h rv1=%b want 1 12345678 0",
                            m0_rvalid, m0_rdata, m1_rvalid);
        end
        model_step(2'b00, 1'b0, '0, '0);
        @(negedge clk);
        #1;
        total++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h12345678) begin
            bad++; $display("FAIL rd_hold: got rv0=%b rd0=%h want 0 12345678", m0_rvalid, m0_rdata);
        end
        model_step(2'b00, 1'b0, '0, '0);
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        drive(0, 0, '0, '0, 1, 1, 32'h20, 32'hDEADBEEF);
        #1;
        total++;
        if ({m0_gnt, m1_gnt, mem_rd, mem_wr} !== 4'b0101 || mem_addr !== 32'h20
            || mem_wdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL wr_grant: got %b addr=%h wdata=%h want 0101 20 deadbeef",
                            {m0_gnt, m1_gnt, mem_rd, mem_wr}, mem_addr, mem_wdata);
        end
        model_step(2'b10, 1'b1, 6'h20, 32'hDEADBEEF);
        @(negedge clk);
        drive(1, 0, 32'h20, '0, 0, 0, '0, '0);
        #1;
        total++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_gnt !== 1'b1) begin
            bad++; $display("FAIL wr_no_rvalid: got rv=%b gnt0=%b want 00 1", {m0_rvalid, m1_rvalid}, m0_gnt);
        end
        model_step(2'b01, 1'b0, 6'h20, '0);
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        total++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rdata !== m_rdata[1]) begin
            bad++; $display("FAIL wr_readback: got rv0=%b rd0=%h rd1=%h want 1 deadbeef %h",
                            m0_rvalid, m0_rdata, m1_rdata, m_rdata[1]);
        end
        model_step(2'b00, 1'b0, '0, '0);
    endtask

    task automatic test_alternating();
        logic [1:0] seq [3];
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(seq[k][0], k == 2, AW'(k + 1), 32'h55AA0000 + k, seq[k][1], 1'b0, AW'(k + 1), '0);
            #1;
            total++;
            if ({m1_gnt, m0_gnt} !== seq[k]) begin
                bad++; $display("FAIL alt_gnt[%0d]: got %b want %b", k, {m1_gnt, m0_gnt}, seq[k]);
            end
            model_step(seq[k], k == 2, 6'(k + 1), 32'h55AA0000 + k);
            @(posedge clk);
            #1;
            total++;
            if (dut.burst_q !== 4'd1) begin
                bad++; $display("FAIL alt_burst[%0d]: got %0d want 1", k, dut.burst_q);
            end
        end
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        total++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m1_rdata !== m_rdata[1]) begin
            bad++; $display("FAIL alt_return: got rv=%b rd1=%h want 00 %h",
                            {m0_rvalid, m1_rvalid}, m1_rdata, m_rdata[1]);
        end
        model_step(2'b00, 1'b0, '0, '0);
    endtask

    task automatic test_contention();
        logic [1:0]    want;
        logic [AW-1:0] a0, a1;
        do_reset();
        a0 = 32'd0; a1 = 32'd32;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            drive(1, 0, a0, '0, 1, 0, a1, '0);
            #1;
            want = (((k / MB) % 2) == 0) ? 2'b01 : 2'b10;
            total++;
            if ({m1_gnt, m0_gnt} !== want) begin
                bad++; $display("FAIL burst_gnt[%0d]: got %b want %b", k, {m1_gnt, m0_gnt}, want);
            end
            total++;
            if (m0_rvalid !== (m_pend && !m_pend_own) || m1_rvalid !== (m_pend && m_pend_own)
                || (m_pend && !m_pend_own && m0_rdata !== m_pend_data)
                || (m_pend && m_pend_own && m1_rdata !== m_pend_data)) begin
                bad++; $display("FAIL burst_return[%0d]: got rv=%b rd0=%h rd1=%h want data %h",
                                k, {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata, m_pend_data);
            end
            model_step(want, 1'b0, want[1] ? a1[5:0] : a0[5:0], '0);
            if (want[1]) a1 = (a1 == 32'd63) ? 32'd32 : a1 + 1;
            else         a0 = (a0 == 32'd31) ? 32'd0  : a0 + 1;
        end
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_step(2'b00, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        drive(1, 0, 32'h05, '0, 0, 0, '0, '0);
        #1;
        total++;
        if (m0_gnt !== 1'b1 || mem_rd !== 1'b1) begin
            bad++; $display("FAIL rst_mid_grant: got gnt0=%b rd=%b want 1 1", m0_gnt, mem_rd);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        total++;
        if (m0_rvalid !== 1'b0 || dut.state_q !== ST_IDLE || dut.burst_q !== 4'd0) begin
            bad++; $display("FAIL rst_mid_drop: got rv0=%b state=%b burst=%0d want 0 00 0",
                            m0_rvalid, dut.state_q, dut.burst_q);
        end
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drive(1, 0, 32'h06, '0, 1, 0, 32'h07, '0);
        #1;
        total++;
        if ({m1_gnt, m0_gnt} !== 2'b01 || m0_rvalid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_tie: got gnt=%b rv0=%b want 01 0", {m1_gnt, m0_gnt}, m0_rvalid);
        end
        model_step(2'b01, 1'b0, 6'h06, '0);
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_step(2'b00, 1'b0, '0, '0);
    endtask

    task automatic test_random();
        logic          p_act [2];
        logic          p_we [2];
        logic [AW-1:0] p_addr [2];
        logic [DW-1:0] p_wd [2];
        logic [1:0]    g;
        logic          w, xwe;
        logic [AW-1:0] xaddr;
        logic [DW-1:0] xwd;
        int            errs;
        do_reset();
        p_act[0] = 1'b0; p_act[1] = 1'b0;
        p_we[0] = 1'b0; p_we[1] = 1'b0;
        p_addr[0] = '0; p_addr[1] = '0;
        p_wd[0] = '0; p_wd[1] = '0;
        errs = 0;
        for (int k = 0; k < 400; k++) begin
            for (int m = 0; m < 2; m++) begin
                if (!p_act[m] && $urandom_range(0, 99) < 65) begin
                    p_act[m]  = 1'b1;
                    p_we[m]   = ($urandom_range(0, 2) == 0);
                    p_addr[m] = AW'($urandom_range(0, 63));
                    p_wd[m]   = $urandom;
                end
            end
            @(negedge clk);
            drive(p_act[0], p_we[0], p_addr[0], p_wd[0], p_act[1], p_we[1], p_addr[1], p_wd[1]);
            #1;
            g     = model_gnt(p_act[0], p_act[1]);
            w     = g[1];
            xwe   = (g != 2'b00) && p_we[w];
            xaddr = (g != 2'b00) ? p_addr[w] : '0;
            xwd   = (g != 2'b00) ? p_wd[w] : '0;
            total++;
            if ({m1_gnt, m0_gnt} !== g) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_gnt[%0d]: got %b want %b", k, {m1_gnt, m0_gnt}, g);
            end
            total++;
            if (mem_rd !== ((g != 2'b00) && !xwe) || mem_wr !== xwe || mem_addr !== xaddr
                || mem_wdata !== xwd) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_mem[%0d]: got rd=%b wr=%b addr=%h wd=%h want %b %b %h %h",
                                        k, mem_rd, mem_wr, mem_addr, mem_wdata,
                                        (g != 2'b00) && !xwe, xwe, xaddr, xwd);
            end
            total++;
            if (m0_rvalid !== (m_pend && !m_pend_own) || m1_rvalid !== (m_pend && m_pend_own)
                || m0_rdata !== ((m_pend && !m_pend_own) ? m_pend_data : m_rdata[0])
                || m1_rdata !== ((m_pend && m_pend_own) ? m_pend_data : m_rdata[1])) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_return[%0d]: got rv=%b rd0=%h rd1=%h pend_data=%h",
                                        k, {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata, m_pend_data);
            end
            model_step(g, xwe, xaddr[5:0], xwd);
            if (g != 2'b00) p_act[w] = 1'b0;
        end
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_step(2'b00, 1'b0, '0, '0);
    endtask

    initial begin
        reset = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_reset();
        test_reset();
        test_single_read();
        test_write_then_read();
        test_alternating();
        test_contention();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
